// File: rtl/cpu_axi_pkg.sv
// Shared types and AXI constants for the CPU-to-AXI burst bridge.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_WR_RESP
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AxSIZE encoding for a bus of data_w bits: log2 of the byte count.
  function automatic logic [2:0] axi_size_from_width(input int unsigned data_w);
    logic [2:0] size;
    size = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == (data_w / 8)) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/cpu_axi_wbeat_reg.sv
// W-channel holding register: beat 0 arrives with the request, later beats via the
// Wdata handshake; a beat counter against the latched length produces wlast.
module cpu_axi_wbeat_reg
  import cpu_axi_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned STRB_W   = DATA_W / 8,
  localparam int unsigned CNT_W    = $clog2(MAX_BEATS)
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset,
  input  logic              start,
  input  logic              active,
  input  logic [CNT_W-1:0]  start_len,
  input  logic [DATA_W-1:0] beat_data,
  input  logic [STRB_W-1:0] beat_strb,
  input  logic              beat_valid,
  output logic              beat_ready,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  output logic              wlast,
  output logic [CNT_W-1:0]  len_q,
  output logic              last_done
);

  logic [CNT_W-1:0]  cnt, cnt_n, len_n;
  logic [DATA_W-1:0] data_n;
  logic [STRB_W-1:0] strb_n;
  logic              wvalid_n, wlast_n, done_n, w_hs;

  assign w_hs = wvalid & wready;
  // wlast is only ever high with wvalid, so ~wlast means another beat is still owed
  assign beat_ready = active & ~last_done & ~wlast & (~wvalid | wready);

  always_comb begin
    cnt_n    = cnt;
    len_n    = len_q;
    data_n   = wdata;
    strb_n   = wstrb;
    wvalid_n = wvalid;
    done_n   = last_done;
    if (start) begin
      cnt_n    = '0;
      len_n    = start_len;
      data_n   = beat_data;
      strb_n   = beat_strb;
      wvalid_n = 1'b1;
      done_n   = 1'b0;
    end else if (active) begin
      if (w_hs) begin
        wvalid_n = 1'b0;
        if (wlast) done_n = 1'b1;
        else       cnt_n  = cnt + CNT_W'(1);
      end
      if (beat_ready && beat_valid) begin
        data_n   = beat_data;
        strb_n   = beat_strb;
        wvalid_n = 1'b1;
      end
    end
    wlast_n = wvalid_n & (cnt_n == len_n);
  end

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      cnt       <= '0;
      len_q     <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      last_done <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      len_q     <= len_n;
      wdata     <= data_n;
      wstrb     <= strb_n;
      wvalid    <= wvalid_n;
      wlast     <= wlast_n;
      last_done <= done_n;
    end
  end

endmodule

// File: rtl/cpu_axi_burst_bridge.sv
// Bridge from the CPU data-port request interface to AXI4 read/write channels,
// supporting INCR bursts up to MAX_BEATS with streamed write data.
module cpu_axi_burst_bridge
  import cpu_axi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned STRB_W   = DATA_W / 8,
  localparam int unsigned CNT_W    = $clog2(MAX_BEATS)
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [7:0]        Len,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [STRB_W-1:0] Write_strb,
  input  logic              Wdata_Valid,
  output logic              Wdata_Ready,
  output logic              Mem_Req_Ready,
  output logic              Wr_Err,
  output logic [DATA_W-1:0] Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ready,
  output logic              Read_data_Last,
  output logic              Read_data_Err,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_e           state, state_n;
  logic [CNT_W-1:0] len_sat, arlen_q, awlen_q;
  logic             rd_start, wr_start, wr_active, last_done, aw_fin, w_fin;
  logic             unused_resp;

  assign len_sat     = (Len > 8'(MAX_BEATS - 1)) ? CNT_W'(MAX_BEATS - 1) : Len[CNT_W-1:0];
  assign arlen       = 8'(arlen_q);
  assign awlen       = 8'(awlen_q);
  assign arsize      = axi_size_from_width(DATA_W);
  assign awsize      = axi_size_from_width(DATA_W);
  assign arburst     = AXI_BURST_INCR;
  assign awburst     = AXI_BURST_INCR;
  assign unused_resp = ^{rresp[0], bresp[0]};

  // awvalid is raised on entry to WR, so a low awvalid there means AW is done
  assign aw_fin = ~awvalid | awready;
  assign w_fin  = last_done | (wvalid & wready & wlast);

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) state <= ST_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (MemWrite)     state_n = ST_WR;
        else if (MemRead) state_n = ST_RD_ADDR;
      end
      ST_RD_ADDR: if (arvalid && arready)                 state_n = ST_RD_DATA;
      ST_RD_DATA: if (rvalid && Read_data_Ready && rlast) state_n = ST_IDLE;
      ST_WR:      if (aw_fin && w_fin)                    state_n = ST_WR_RESP;
      ST_WR_RESP: if (bvalid)                             state_n = ST_IDLE;
      default:                                            state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    Mem_Req_Ready   = 1'b0;
    Wr_Err          = 1'b0;
    Read_data       = '0;
    Read_data_Valid = 1'b0;
    Read_data_Last  = 1'b0;
    Read_data_Err   = 1'b0;
    rready          = 1'b0;
    bready          = 1'b0;
    rd_start        = 1'b0;
    wr_start        = 1'b0;
    wr_active       = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_start = MemWrite;
        rd_start = MemRead & ~MemWrite;
      end
      ST_RD_ADDR: Mem_Req_Ready = arvalid & arready;
      ST_RD_DATA: begin
        Read_data       = rdata;
        Read_data_Valid = rvalid;
        Read_data_Last  = rlast;
        Read_data_Err   = rresp[1];
        rready          = Read_data_Ready;
      end
      ST_WR: wr_active = 1'b1;
      ST_WR_RESP: begin
        bready        = 1'b1;
        Mem_Req_Ready = bvalid;
        Wr_Err        = bvalid & bresp[1];
      end
      default: ;
    endcase
  end

  // Address channels: latch on request, drop valid on handshake
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      araddr  <= '0;
      arlen_q <= '0;
      arvalid <= 1'b0;
      awaddr  <= '0;
      awlen_q <= '0;
      awvalid <= 1'b0;
    end else begin
      if (rd_start) begin
        araddr  <= Address;
        arlen_q <= len_sat;
        arvalid <= 1'b1;
      end else if (arvalid && arready) begin
        arvalid <= 1'b0;
      end
      if (wr_start) begin
        awaddr  <= Address;
        awlen_q <= len_sat;
        awvalid <= 1'b1;
      end else if (awvalid && awready) begin
        awvalid <= 1'b0;
      end
    end
  end

  cpu_axi_wbeat_reg #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) u_wbeat (
    .cpu_clk    (cpu_clk),
    .cpu_reset  (cpu_reset),
    .start      (wr_start),
    .active     (wr_active),
    .start_len  (len_sat),
    .beat_data  (Write_data),
    .beat_strb  (Write_strb),
    .beat_valid (Wdata_Valid),
    .beat_ready (Wdata_Ready),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wlast      (wlast),
    .len_q      (),
    .last_done  (last_done)
  );

endmodule

// File: tb/tb_cpu_axi_burst_bridge.sv
// Self-checking bench for cpu_axi_burst_bridge: table of transactions, hand-written
// corner sequences and a random loop, all checked against a transaction-level model.
module tb_cpu_axi_burst_bridge;
  import cpu_axi_pkg::*;

  localparam int unsigned ADDR_W = 32, DATA_W = 32, STRB_W = 4, MAX_BEATS = 16;

  logic cpu_clk = 1'b0;
  logic cpu_reset;
  logic [ADDR_W-1:0] Address, araddr, awaddr;
  logic [7:0]        Len, arlen, awlen;
  logic              MemRead, MemWrite, Wdata_Valid, Wdata_Ready, Mem_Req_Ready, Wr_Err;
  logic [DATA_W-1:0] Write_data, Read_data, rdata, wdata;
  logic [STRB_W-1:0] Write_strb, wstrb;
  logic              Read_data_Valid, Read_data_Ready, Read_data_Last, Read_data_Err;
  logic [2:0]        arsize, awsize;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic              arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic              wlast, wvalid, wready, bvalid, bready;

  always #5 cpu_clk = ~cpu_clk;

  cpu_axi_burst_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .Address(Address), .Len(Len),
    .MemRead(MemRead), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .Wdata_Valid(Wdata_Valid), .Wdata_Ready(Wdata_Ready), .Mem_Req_Ready(Mem_Req_Ready),
    .Wr_Err(Wr_Err), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready), .Read_data_Last(Read_data_Last),
    .Read_data_Err(Read_data_Err), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: beats in a burst = saturated Len + 1
  function automatic int model_beats(input int len);
    return ((len > MAX_BEATS - 1) ? MAX_BEATS - 1 : len) + 1;
  endfunction

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; Address = '0; Len = '0; Write_data = '0; Write_strb = '0;
    Wdata_Valid = 0; Read_data_Ready = 0; arready = 0; rdata = '0; rresp = '0; rlast = 0;
    rvalid = 0; awready = 0; wready = 0; bresp = '0; bvalid = 0;
  endtask

  // mode 0: all ready/valid held high; otherwise randomised handshakes
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] resp,
                          input logic [7:0] exp_len, input int aw_delay, input int mode,
                          input bit hold_read, input int stop_at,
                          output int first_w, output int last_w, output int beats);
    logic [31:0] bd[$];
    logic [3:0]  bs[$];
    int nb, cpu_idx, c, b_delay;
    bit aw_ok, done;
    nb = model_beats(int'(len));
    for (int i = 0; i < nb; i++) begin
      bd.push_back($urandom);
      bs.push_back(4'($urandom_range(1, 15)));
    end
    cpu_idx = 1; c = 0; aw_ok = 0; done = 0; beats = 0; first_w = -1; last_w = -1;
    b_delay = $urandom_range(0, 2);
    MemWrite = 1; MemRead = hold_read; Address = addr; Len = len;
    Write_data = bd[0]; Write_strb = bs[0]; Wdata_Valid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = resp;
    while (!done && c < 400 && !(stop_at > 0 && c == stop_at)) begin
      #1;
      if (hold_read) chk("arvalid_during_write", arvalid, 0);
      if (c == 0)      chk("awvalid_latency", awvalid, 0);
      else if (!aw_ok) chk("awvalid_held", awvalid, 1);
      else             chk("awvalid_dropped", awvalid, 0);
      if (awvalid && awready) begin
        chk("awaddr", awaddr, addr);
        chk("awlen", awlen, exp_len);
        chk("awsize", awsize, 3'd2);
        chk("awburst", awburst, AXI_BURST_INCR);
        aw_ok = 1;
      end
      if (wvalid && wready) begin
        if (beats < nb) begin
          chk("wdata", wdata, bd[beats]);
          chk("wstrb", wstrb, bs[beats]);
          chk("wlast", wlast, beats == nb - 1);
        end else begin
          chk("extra_w_beat", beats, nb - 1);
        end
        if (first_w < 0) first_w = c;
        last_w = c;
        beats++;
      end
      if (Wdata_Valid && Wdata_Ready) cpu_idx++;
      chk("mem_req_ready_write", Mem_Req_Ready, bvalid);
      if (Mem_Req_Ready) begin
        chk("wr_err", Wr_Err, resp[1]);
        chk("w_beats_before_b", beats, nb);
        chk("aw_before_b", aw_ok, 1);
        done = 1;
      end
      step();
      c++;
      if (done) begin
        MemWrite = 0; bvalid = 0; Wdata_Valid = 0; awready = 0; wready = 0;
      end else begin
        Write_data  = bd[(cpu_idx < nb) ? cpu_idx : nb - 1];
        Write_strb  = bs[(cpu_idx < nb) ? cpu_idx : nb - 1];
        Wdata_Valid = (cpu_idx < nb) && (mode == 0 || $urandom_range(0, 1) == 1);
        awready     = (c >= aw_delay) && (mode == 0 || $urandom_range(0, 1) == 1);
        wready      = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (aw_ok && beats == nb) begin
          if (b_delay == 0) bvalid = 1;
          else              b_delay--;
        end
      end
    end
    if (stop_at == 0) chk("write_completed", done, 1);
  endtask

  // mode 0: ready/rvalid high; 1: Read_data_Ready alternates; 2: random both
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0,
                         input logic [7:0] exp_len, input int ar_delay, input int mode,
                         input int err_beat, output int mrr_cycle, output int n_mrr,
                         output int beats);
    logic [31:0] rd[$];
    int nb, c;
    bit ar_ok, done, data_phase, r_pend;
    nb = model_beats(int'(len));
    rd.push_back(d0);
    for (int i = 1; i < nb; i++) rd.push_back($urandom);
    c = 0; ar_ok = 0; done = 0; data_phase = 0; r_pend = 0; beats = 0; n_mrr = 0; mrr_cycle = -1;
    MemRead = 1; MemWrite = 0; Address = addr; Len = len;
    arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = '0; Read_data_Ready = 0;
    while (!done && c < 400) begin
      #1;
      chk("arvalid_read", arvalid, c >= 1 && !ar_ok);
      chk("mrr_read", Mem_Req_Ready, c >= 1 && !ar_ok && arready);
      if (Mem_Req_Ready) begin n_mrr++; mrr_cycle = c; end
      if (arvalid && arready) begin
        chk("araddr", araddr, addr);
        chk("arlen", arlen, exp_len);
        chk("arsize", arsize, 3'd2);
        chk("arburst", arburst, AXI_BURST_INCR);
        ar_ok = 1;
      end
      if (data_phase) begin
        chk("rready_pass", rready, Read_data_Ready);
        chk("rvalid_pass", Read_data_Valid, rvalid);
        r_pend = rvalid && !Read_data_Ready;
        if (rvalid && Read_data_Ready) begin
          chk("read_data", Read_data, rd[beats]);
          chk("read_last", Read_data_Last, beats == nb - 1);
          chk("read_err", Read_data_Err, beats == err_beat);
          beats++;
          if (beats == nb) done = 1;
        end
      end else begin
        chk("rready_pre_data", rready, 0);
      end
      step();
      c++;
      if (n_mrr > 0) MemRead = 0;
      if (ar_ok) data_phase = 1;
      arready = !ar_ok && (c >= 1 + ar_delay) && (mode != 2 || $urandom_range(0, 1) == 1);
      Read_data_Ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((c % 2) == 1)
                                                        : 1'($urandom_range(0, 1));
      if (data_phase && !done) begin
        rdata = rd[beats];
        rlast = (beats == nb - 1);
        rresp = (beats == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (!r_pend) rvalid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        rvalid = 0; rlast = 0;
      end
    end
    chk("read_completed", done, 1);
    Read_data_Ready = 1;
    #1;
    chk("rready_after_last", rready, 0);
    Read_data_Ready = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  resp;
    int          delay;
    int          mode;
    int          err_beat;
    int          exp_beats;
    logic [7:0]  exp_axlen;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int fw, lw, nb, mc, nm, rlen, rwr;
    vecs[0] = '{1'b1, 32'h0000_0100, 8'd0,   AXI_RESP_OKAY,   0, 0, -1, 1,  8'd0};
    vecs[1] = '{1'b1, 32'h0000_0200, 8'd3,   AXI_RESP_OKAY,   6, 0, -1, 4,  8'd3};
    vecs[2] = '{1'b1, 32'h0000_0300, 8'd3,   AXI_RESP_SLVERR, 1, 1, -1, 4,  8'd3};
    vecs[3] = '{1'b1, 32'h0000_0400, 8'd15,  AXI_RESP_OKAY,   2, 1, -1, 16, 8'd15};
    vecs[4] = '{1'b1, 32'h0000_0500, 8'd200, AXI_RESP_DECERR, 0, 0, -1, 16, 8'd15};
    vecs[5] = '{1'b0, 32'h0000_0600, 8'd0,   AXI_RESP_OKAY,   0, 0, 0,  1,  8'd0};
    vecs[6] = '{1'b0, 32'h0000_0700, 8'd3,   AXI_RESP_OKAY,   1, 1, -1, 4,  8'd3};
    vecs[7] = '{1'b0, 32'h0000_0800, 8'd16,  AXI_RESP_OKAY,   2, 2, 7,  16, 8'd15};
    vecs[8] = '{1'b0, 32'h0000_0900, 8'd7,   AXI_RESP_OKAY,   0, 2, 5,  8,  8'd7};

    // Reset state
    idle_inputs();
    cpu_reset = 1;
    step(); step();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_mrr", Mem_Req_Ready, 0);
    chk("rst_wdata_ready", Wdata_Ready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_wr_err", Wr_Err, 0);
    chk("rst_addr", {araddr, awaddr}, 64'd0);
    chk("rst_wdata", wdata, 0);
    cpu_reset = 0;
    step();

    // Single read, arready delayed 3 cycles
    do_read(32'h0000_1000, 8'd0, 32'hDEAD_BEEF, 8'd0, 3, 0, -1, mc, nm, nb);
    chk("single_read_mrr_count", nm, 1);
    chk("single_read_mrr_cycle", mc, 4);
    chk("single_read_beats", nb, 1);

    // Read burst with Read_data_Ready low every other cycle
    do_read(32'h0000_2000, 8'd3, $urandom, 8'd3, 0, 1, -1, mc, nm, nb);
    chk("alt_read_beats", nb, 4);

    // Write burst at full rate, AW after the last W
    do_write(32'h0000_3000, 8'd3, AXI_RESP_OKAY, 8'd3, 7, 0, 1'b0, 0, fw, lw, nb);
    chk("write_beats", nb, 4);
    chk("write_back_to_back", lw - fw, 3);

    // SLVERR write response
    do_write(32'h0000_3100, 8'd1, AXI_RESP_SLVERR, 8'd1, 0, 0, 1'b0, 0, fw, lw, nb);

    // Both strobes high, Len saturated: write first, then the read
    do_write(32'h0000_4000, 8'd255, AXI_RESP_OKAY, 8'd15, 0, 0, 1'b1, 0, fw, lw, nb);
    chk("prio_write_beats", nb, 16);
    do_read(32'h0000_4000, 8'd255, $urandom, 8'd15, 0, 0, -1, mc, nm, nb);
    chk("prio_read_beats", nb, 16);

    // Reset in the middle of a write burst
    do_write(32'h0000_5000, 8'd7, AXI_RESP_OKAY, 8'd7, 10, 0, 1'b0, 3, fw, lw, nb);
    #1;
    chk("pre_reset_wvalid", wvalid, 1);
    chk("pre_reset_awvalid", awvalid, 1);
    cpu_reset = 1;
    #1;
    chk("mid_reset_wvalid", wvalid, 0);
    chk("mid_reset_awvalid", awvalid, 0);
    chk("mid_reset_arvalid", arvalid, 0);
    chk("mid_reset_wdata_ready", Wdata_Ready, 0);
    chk("mid_reset_bready", bready, 0);
    idle_inputs();
    step();
    cpu_reset = 0;
    step();
    do_write(32'h0000_6000, 8'd2, AXI_RESP_OKAY, 8'd2, 1, 1, 1'b0, 0, fw, lw, nb);
    chk("post_reset_write_beats", nb, 3);

    // Table of transactions
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].len, vecs[i].resp, vecs[i].exp_axlen, vecs[i].delay,
                 vecs[i].mode, 1'b0, 0, fw, lw, nb);
      end else begin
        do_read(vecs[i].addr, vecs[i].len, $urandom, vecs[i].exp_axlen, vecs[i].delay,
                vecs[i].mode, vecs[i].err_beat, mc, nm, nb);
        chk("vec_read_mrr_count", nm, 1);
      end
      chk("vec_beats", nb, vecs[i].exp_beats);
    end

    // Random transactions against the model
    for (int i = 0; i < 16; i++) begin
      rwr  = $urandom_range(0, 1);
      rlen = ($urandom_range(0, 5) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
      if (rwr == 1) begin
        do_write({$urandom_range(0, 32'hFFFF), 2'b00}, 8'(rlen), 2'($urandom_range(0, 3)),
                 8'(model_beats(rlen) - 1), $urandom_range(0, 4), 2, 1'b0, 0, fw, lw, nb);
      end else begin
        do_read({$urandom_range(0, 32'hFFFF), 2'b00}, 8'(rlen), $urandom,
                8'(model_beats(rlen) - 1), $urandom_range(0, 3), 2,
                $urandom_range(0, model_beats(rlen)), mc, nm, nb);
      end
      chk("rand_beats", nb, model_beats(rlen));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
